ahb_arbiter: RTL and testbench
==============================

Name: ahb_arbiter

Overview:
Central AHB 2.0 bus arbiter that shares one AHB segment among up to 16 ahb_master instances. It takes per-master bus requests and lock requests and drives per-master grants. It drives HMASTER and HMASTLOCK to slaves and the address/data mux, and tracks SPLIT-masked masters. It follows fixed-length bursts so that grant handover happens only at legal points.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
DEFAULT_MASTER, 0, index granted when no eligible request exists; must drive IDLE

Ports:
i_hclk  in  1  AHB clock
i_hreset_n  in  1  asynchronous active-low reset
i_hbusreq  in  NUM_MASTERS  per-master bus request
i_hlock  in  NUM_MASTERS  per-master locked-transfer request
i_htrans  in  2  HTRANS of current bus owner (muxed)
i_hburst  in  3  HBURST of current bus owner (muxed)
i_hready  in  1  bus HREADY
i_hresp  in  2  bus HRESP
i_hsplit  in  NUM_MASTERS  OR of slave HSPLITx; bit i releases master i
o_hgrant  out  NUM_MASTERS  one-hot grant, registered
o_hmaster  out  4  address-phase owner index, registered
o_hmastlock  out  1  current address phase is locked, registered

Behaviour:
- Reset (async): o_hgrant = one-hot(DEFAULT_MASTER); o_hmaster = DEFAULT_MASTER; o_hmastlock = 0; split_mask = 0; beats_left = 0; rr_ptr = DEFAULT_MASTER; data-phase owner dmaster = DEFAULT_MASTER.
- Ownership: on every edge with i_hready=1, o_hmaster <= index(o_hgrant), o_hmastlock <= i_hlock[index(o_hgrant)], dmaster <= o_hmaster. Nothing changes when i_hready=0, except the SPLIT/RETRY handling below.
- Burst tracker beats_left, 5 bits: load on edge with i_hready=1 and i_htrans=NONSEQ.
  - INCR4 → 3; INCR8 → 7; INCR16 → 15; WRAP4/8/16 handled the same as INCR4/8/16.
  - SINGLE or INCR → 0.
  - Decrement on hready edge with i_htrans=SEQ when beats_left>0. BUSY and IDLE hold it.
- States:
  - FREE: beats_left=0, not locked.
  - BURST: beats_left>0.
  - LOCKED: i_hlock[granted]=1.
- arb_ok = !i_hlock[index(o_hgrant)] && (beats_left==0 || (beats_left==1 && i_htrans==SEQ)).
  - The grant therefore moves on the edge accepting the penultimate beat.
  - The old owner keeps exactly one more address phase: its final beat.
- Grant update happens only on an edge with i_hready=1 && arb_ok.
  - Eligible set = i_hbusreq & ~split_mask.
  - Round-robin search starts at rr_ptr+1 mod NUM_MASTERS; the first eligible index wins, and rr_ptr <= winner.
  - If the current grantee is still requesting and no other master is eligible, it keeps the grant.
  - If the set is empty, the grant goes to DEFAULT_MASTER.
- Early termination: if a master inserts BUSY after losing the grant, its burst is truncated. The master re-issues a NONSEQ when regranted. No arbiter action is needed.
- SPLIT/RETRY first cycle (i_hresp ∈ {SPLIT, RETRY} && i_hready=0):
  - beats_left <= 0, so the next hready edge is an arbitration point.
  - On SPLIT only, split_mask[dmaster] <= 1.
  - ERROR also clears beats_left.
- Split release: split_mask <= split_mask & ~i_hsplit every cycle. If set and release hit the same bit in the same cycle, set wins.
- Masked master: its request is ignored. If DEFAULT_MASTER is masked it may still be granted, and it must drive IDLE.
- Lock: while the granted master holds i_hlock, the grant never moves and SPLIT masking still applies. The slave is required to return RETRY, not SPLIT, on locked transfers.
- Latency: request to o_hgrant is 1 cycle in FREE. Grant to o_hmaster is the next hready edge.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS, HBURST and HRESP localparams (IDLE/BUSY/NONSEQ/SEQ, SINGLE..INCR16, OKAY/ERROR/SPLIT/RETRY).
  - Function burst_len(hburst) returning 0/3/7/15.
- Sub-module ahb_rr_pick: combinational one-hot round-robin picker with inputs req vector and pointer, and outputs one-hot grant, index and valid flag.

Test Plan:
- Reset, then no requests → o_hgrant=0001, o_hmaster=0, o_hmastlock=0, constant for 20 cycles.
- i_hbusreq=0110 held, master 1 does SINGLE NONSEQs, rr_ptr starts at 0:
  - grant goes to 0010 after 1 cycle.
  - on the next arbitration point the grant goes to 0100, and alternation continues.
- Master 1 granted issues INCR4 with hready=1 throughout, master 2 requesting:
  - o_hgrant changes to 0100 at the edge accepting beat 3.
  - o_hmaster=1 for all 4 address phases, then o_hmaster=2.
- Master 2 sets i_hlock=1 during INCR8 with master 3 requesting → grant stays 0100 until i_hlock[2]=0; o_hmastlock=1 during the locked address phases.
- Master 1 gets SPLIT (hresp=SPLIT, hready=0 then 1) with i_hbusreq=0011:
  - split_mask=0010 and the grant goes to master 0.
  - after i_hsplit=0010 pulses for 1 cycle, master 1 is granted at the next arbitration point.
- Assert i_hreset_n=0 mid INCR16 at beat 5 → all outputs return to reset values immediately; after release, beats_left=0 and the grant follows the FREE-state rules.

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB 2.0 encodings shared by the arbiter slice, plus the fixed-burst length
// lookup used by the burst tracker.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  // Beats still to come after the NONSEQ of a fixed-length burst.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    logic [4:0] len;
    case (hburst)
      HBURST_SINGLE, HBURST_INCR:   len = 5'd0;
      HBURST_WRAP4,  HBURST_INCR4:  len = 5'd3;
      HBURST_WRAP8,  HBURST_INCR8:  len = 5'd7;
      HBURST_WRAP16, HBURST_INCR16: len = 5'd15;
      default:                      len = 5'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i searching upward
// from ptr_i+1 (wrapping), with ptr_i itself considered last.
module ahb_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [3:0]   ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [3:0]   idx_o,
  output logic         valid_o
);

  logic hit_s;

  // Walk the candidates in priority order, latching the first hit.
  always_comb begin
    gnt_o   = '0;
    idx_o   = 4'd0;
    valid_o = 1'b0;
    hit_s   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        hit_s      = req_i[j] && (j == ((int'(ptr_i) + k) % N)) && !valid_o;
        gnt_o[j]   = gnt_o[j] | hit_s;
        idx_o      = hit_s ? 4'(j) : idx_o;
        valid_o    = valid_o | hit_s;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB 2.0 bus arbiter: round-robin grant that only hands over at burst
// boundaries, honours HLOCK, and masks SPLIT masters until released.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   i_hclk,
  input  logic                   i_hreset_n,
  input  logic [NUM_MASTERS-1:0] i_hbusreq,
  input  logic [NUM_MASTERS-1:0] i_hlock,
  input  logic [1:0]             i_htrans,
  input  logic [2:0]             i_hburst,
  input  logic                   i_hready,
  input  logic [1:0]             i_hresp,
  input  logic [NUM_MASTERS-1:0] i_hsplit,
  output logic [NUM_MASTERS-1:0] o_hgrant,
  output logic [3:0]             o_hmaster,
  output logic                   o_hmastlock
);

  localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT = NUM_MASTERS'(1'b1) << DEFAULT_MASTER;
  localparam logic [3:0]             DEF_IDX    = 4'(DEFAULT_MASTER);

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] split_q, split_d;
  logic [3:0]             hmaster_q, hmaster_d;
  logic [3:0]             dmaster_q, dmaster_d;
  logic [3:0]             rr_q, rr_d;
  logic [4:0]             beats_q, beats_d;
  logic                   hmastlock_q, hmastlock_d;

  logic [3:0]             gidx_s;
  logic                   lock_cur_s;
  logic [NUM_MASTERS-1:0] split_set_s;
  logic [4:0]             beats_nx_s;
  logic                   arb_ok_s;
  logic [NUM_MASTERS-1:0] pick_gnt_s;
  logic [3:0]             pick_idx_s;
  logic                   pick_valid_s;

  ahb_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req_i   (i_hbusreq & ~split_q),
    .ptr_i   (rr_q),
    .gnt_o   (pick_gnt_s),
    .idx_o   (pick_idx_s),
    .valid_o (pick_valid_s)
  );

  // Grantee index and its lock request, plus the SPLIT mask set vector.
  always_comb begin
    gidx_s      = 4'd0;
    lock_cur_s  = 1'b0;
    split_set_s = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      gidx_s         = gidx_s | (grant_q[k] ? 4'(k) : 4'd0);
      lock_cur_s     = lock_cur_s | (grant_q[k] & i_hlock[k]);
      split_set_s[k] = (i_hresp == HRESP_SPLIT) && !i_hready && (dmaster_q == 4'(k));
    end
  end

  // Beats left once the current address phase is accepted. Arbitrating on
  // this value keeps the NONSEQ of a fixed burst from being a handover point.
  always_comb begin
    beats_nx_s = beats_q;
    case (i_htrans)
      HTRANS_NONSEQ: beats_nx_s = burst_len(i_hburst);
      HTRANS_SEQ:    beats_nx_s = (beats_q != 5'd0) ? (beats_q - 5'd1) : 5'd0;
      HTRANS_IDLE,
      HTRANS_BUSY:   beats_nx_s = beats_q;
      default:       beats_nx_s = beats_q;
    endcase
    arb_ok_s = !lock_cur_s &&
               ((beats_nx_s == 5'd0) || ((beats_nx_s == 5'd1) && (i_htrans == HTRANS_SEQ)));
  end

  // Next-state for ownership, burst tracking, grant and split mask.
  always_comb begin
    grant_d     = grant_q;
    rr_d        = rr_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    dmaster_d   = dmaster_q;
    beats_d     = beats_q;
    split_d     = (split_q & ~i_hsplit) | split_set_s;
    if (i_hready) begin
      hmaster_d   = gidx_s;
      hmastlock_d = lock_cur_s;
      dmaster_d   = hmaster_q;
      beats_d     = beats_nx_s;
      if (arb_ok_s && pick_valid_s) begin
        grant_d = pick_gnt_s;
        rr_d    = pick_idx_s;
      end else if (arb_ok_s) begin
        grant_d = DEF_ONEHOT;
      end else begin
        grant_d = grant_q;
      end
    end else if ((i_hresp == HRESP_ERROR) || (i_hresp == HRESP_SPLIT) ||
                 (i_hresp == HRESP_RETRY)) begin
      beats_d = 5'd0;
    end else begin
      beats_d = beats_q;
    end
  end

  // State registers.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      grant_q     <= DEF_ONEHOT;
      split_q     <= '0;
      hmaster_q   <= DEF_IDX;
      dmaster_q   <= DEF_IDX;
      rr_q        <= DEF_IDX;
      beats_q     <= 5'd0;
      hmastlock_q <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      split_q     <= split_d;
      hmaster_q   <= hmaster_d;
      dmaster_q   <= dmaster_d;
      rr_q        <= rr_d;
      beats_q     <= beats_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign o_hgrant    = grant_q;
  assign o_hmaster   = hmaster_q;
  assign o_hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: a per-cycle vector table for round-robin,
// burst handover, lock and SPLIT, plus hand sequences for idle and reset.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [1:0] hresp;
  logic [3:0] hsplit;
  logic [3:0] hgrant;
  logic [3:0] hmaster;
  logic       hmastlock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       rdy;
    logic [1:0] resp;
    logic [3:0] split;
    logic [3:0] e_gnt;
    logic [3:0] e_mst;
    logic       e_lck;
  } vec_t;

  vec_t vq[$];

  ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .i_hclk      (clk),
    .i_hreset_n  (rst_n),
    .i_hbusreq   (hbusreq),
    .i_hlock     (hlock),
    .i_htrans    (htrans),
    .i_hburst    (hburst),
    .i_hready    (hready),
    .i_hresp     (hresp),
    .i_hsplit    (hsplit),
    .o_hgrant    (hgrant),
    .o_hmaster   (hmaster),
    .o_hmastlock (hmastlock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eg, input logic [3:0] em, input logic el);
    chk({tag, " hgrant"},    32'(hgrant),    32'(eg));
    chk({tag, " hmaster"},   32'(hmaster),   32'(em));
    chk({tag, " hmastlock"}, 32'(hmastlock), 32'(el));
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                       input logic [2:0] burst, input logic rdy, input logic [1:0] resp,
                       input logic [3:0] split);
    hbusreq = req; hlock = lock; htrans = trans; hburst = burst;
    hready = rdy; hresp = resp; hsplit = split;
  endtask

  task automatic add(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                     input logic [2:0] burst, input logic rdy, input logic [1:0] resp,
                     input logic [3:0] split, input logic [3:0] eg, input logic [3:0] em,
                     input logic el);
    vq.push_back('{req, lock, trans, burst, rdy, resp, split, eg, em, el});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0000);

    // Round-robin between masters 1 and 2, master 1 issuing SINGLEs.
    add(4'b0110, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0000, 4'b0010, 4'd0, 1'b0);
    add(4'b0110, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0000, 4'b0100, 4'd1, 1'b0);
    add(4'b0110, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0000, 4'b0010, 4'd2, 1'b0);
    add(4'b0110, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0000, 4'b0100, 4'd1, 1'b0);
    add(4'b0110, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0000, 4'b0010, 4'd2, 1'b0);
    // Master 1 INCR4 with master 2 waiting: handover on the beat-3 edge.
    add(4'b0010, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0000, 4'b0010, 4'd1, 1'b0);
    add(4'b0110, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, HRESP_OKAY,  4'b0000, 4'b0010, 4'd1, 1'b0);
    add(4'b0110, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, HRESP_OKAY,  4'b0000, 4'b0010, 4'd1, 1'b0);
    add(4'b0110, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, HRESP_OKAY,  4'b0000, 4'b0100, 4'd1, 1'b0);
    add(4'b0100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, HRESP_OKAY,  4'b0000, 4'b0100, 4'd2, 1'b0);
    // Master 2 locked INCR8 with master 3 requesting.
    add(4'b1100, 4'b0100, HTRANS_NONSEQ, HBURST_INCR8,  1'b1, HRESP_OKAY,  4'b0000, 4'b0100, 4'd2, 1'b1);
    for (int i = 0; i < 7; i++)
      add(4'b1100, 4'b0100, HTRANS_SEQ,  HBURST_INCR8,  1'b1, HRESP_OKAY,  4'b0000, 4'b0100, 4'd2, 1'b1);
    add(4'b1100, 4'b0100, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0000, 4'b0100, 4'd2, 1'b1);
    add(4'b1100, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0000, 4'b1000, 4'd2, 1'b0);
    // Master 1 SPLIT, masked, then released by HSPLIT.
    add(4'b0010, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0000, 4'b0010, 4'd3, 1'b0);
    add(4'b0010, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0000, 4'b0010, 4'd1, 1'b0);
    add(4'b0010, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0000, 4'b0010, 4'd1, 1'b0);
    add(4'b0011, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, HRESP_SPLIT, 4'b0000, 4'b0010, 4'd1, 1'b0);
    add(4'b0011, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_SPLIT, 4'b0000, 4'b0001, 4'd1, 1'b0);
    add(4'b0011, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0000, 4'b0001, 4'd0, 1'b0);
    add(4'b0011, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0010, 4'b0001, 4'd0, 1'b0);
    add(4'b0011, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0000, 4'b0010, 4'd0, 1'b0);

    // Reset values while reset is held.
    tick();
    tick();
    chk_out("reset", 4'b0001, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // No requests: grant parks on the default master.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_out($sformatf("idle%0d", i), 4'b0001, 4'd0, 1'b0);
    end

    foreach (vq[i]) begin
      drive(vq[i].req, vq[i].lock, vq[i].trans, vq[i].burst, vq[i].rdy, vq[i].resp, vq[i].split);
      tick();
      chk_out($sformatf("v%0d", i), vq[i].e_gnt, vq[i].e_mst, vq[i].e_lck);
    end

    // Master 1 starts an INCR16; reset lands during its fifth address phase.
    drive(4'b0010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0000);
    tick();
    chk_out("b16 own", 4'b0010, 4'd1, 1'b0);
    drive(4'b0110, 4'b0000, HTRANS_NONSEQ, HBURST_INCR16, 1'b1, HRESP_OKAY, 4'b0000);
    tick();
    chk_out("b16 nonseq", 4'b0010, 4'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(4'b0110, 4'b0000, HTRANS_SEQ, HBURST_INCR16, 1'b1, HRESP_OKAY, 4'b0000);
      tick();
      chk_out($sformatf("b16 seq%0d", i), 4'b0010, 4'd1, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async rst", 4'b0001, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0000);
    tick();
    chk_out("post rst", 4'b0010, 4'd0, 1'b0);
    // A stale SEQ must not hold the grant: the tracker was cleared by reset.
    drive(4'b0110, 4'b0000, HTRANS_SEQ, HBURST_INCR16, 1'b1, HRESP_OKAY, 4'b0000);
    tick();
    chk_out("post rst free", 4'b0100, 4'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
